// File: rtl/arp_responder.sv
// -----------------------------------------------------------------------------
// arp_responder
//
// ARP reply engine on an 8-bit AXI-Stream byte path, placed next to the
// Ethernet MAC. Received Ethernet+ARP frames (no preamble/FCS) are parsed on
// the fly. An IPv4 ARP request for P_DUT_IPV4 is answered with a 42-byte ARP
// reply that advertises P_DUT_MAC. Every other frame is consumed and dropped.
//
// Optional feature macro: ARP_DA_FILTER_EN
//   defined   - a request is answered only when its destination MAC is
//               broadcast (FF:FF:FF:FF:FF:FF) or P_DUT_MAC.
//   undefined - the destination MAC is ignored.
//
// Ports
//   I_CLK          in   1  single clock, rising edge
//   I_RESET        in   1  asynchronous active-low reset
//   S_AXIS_TREADY  out  1  rx ready (registered)
//   S_AXIS_TVALID  in   1  rx byte valid
//   S_AXIS_TUSER   in   1  rx end-of-frame, high on last byte
//   S_AXIS_TDATA   in   8  rx byte, network order
//   M_AXIS_TREADY  in   1  tx ready from downstream
//   M_AXIS_TVALID  out  1  tx byte valid (registered)
//   M_AXIS_TUSER   out  1  tx end-of-frame, high on reply byte 41 only
//   M_AXIS_TDATA   out  8  tx byte, network order (registered)
// -----------------------------------------------------------------------------
module arp_responder #(
    parameter logic [31:0] P_DUT_IPV4 = 32'hC0A8_0164,
    parameter logic [47:0] P_DUT_MAC  = 48'h02_00_00_00_00_01
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    output logic       S_AXIS_TREADY,
    input  logic       S_AXIS_TVALID,
    input  logic       S_AXIS_TUSER,
    input  logic [7:0] S_AXIS_TDATA,
    input  logic       M_AXIS_TREADY,
    output logic       M_AXIS_TVALID,
    output logic       M_AXIS_TUSER,
    output logic [7:0] M_AXIS_TDATA
);

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_SKIP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_TX    = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  rx_cnt_r, rx_cnt_s;        // index of the next rx byte
    logic [5:0]  tx_cnt_r, tx_cnt_s;        // index of the reply byte on the bus
    logic        fields_ok_r, fields_ok_s;  // fixed header fields and TPA all matched so far
    logic [1:0]  da_hits_r, da_hits_s;      // {DA is broadcast, DA is P_DUT_MAC} so far
    logic [79:0] sha_spa_r, sha_spa_s;      // request SHA (upper 48) and SPA (lower 32)
    logic        s_tready_r, s_tready_s;
    logic        m_tvalid_r, m_tvalid_s;
    logic        m_tuser_r, m_tuser_s;
    logic [7:0]  m_tdata_r, m_tdata_s;

    logic        rx_beat_s;
    logic        tx_beat_s;
    logic        first_s;
    logic        match_s;

    // Does rx byte idx agree with what an answerable request carries there?
    // Only the fixed ARP/IPv4 header bytes and the TPA bytes are constrained.
    function automatic logic req_byte_ok(input logic [7:0] idx, input logic [7:0] data);
        logic [79:0] hdr;
        logic        ok;
        hdr = {16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001};
        if ((idx >= 8'd12) && (idx <= 8'd21)) begin
            ok = (data == 8'(hdr >> {4'(8'd21 - idx), 3'b000}));
        end else if ((idx >= 8'd38) && (idx <= 8'd41)) begin
            ok = (data == 8'(P_DUT_IPV4 >> {2'(8'd41 - idx), 3'b000}));
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Per-byte destination MAC hits {broadcast, local}; both forced true when
    // the DA filter is not built in, so the DA never blocks a match.
    function automatic logic [1:0] da_byte_hits(input logic [7:0] idx, input logic [7:0] data);
        logic [1:0] hits;
        if (idx > 8'd5) begin
            hits = 2'b11;
        end else begin
            hits = {data == 8'hFF, data == 8'(P_DUT_MAC >> {3'(8'd5 - idx), 3'b000})};
        end
`ifndef ARP_DA_FILTER_EN
        hits = 2'b11;
`endif
        return hits;
    endfunction

    // Reply byte idx (0..41) built from the captured request SHA/SPA.
    function automatic logic [7:0] reply_byte(input logic [5:0] idx, input logic [79:0] sha_spa);
        logic [335:0] frame;
        frame = {sha_spa[79:32], P_DUT_MAC,
                 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                 P_DUT_MAC, P_DUT_IPV4, sha_spa[79:32], sha_spa[31:0]};
        return 8'(frame >> {6'd41 - idx, 3'b000});
    endfunction

    assign rx_beat_s = S_AXIS_TVALID & s_tready_r;
    assign tx_beat_s = m_tvalid_r & M_AXIS_TREADY;
    assign first_s   = (rx_cnt_r == 8'd0);
    assign match_s   = fields_ok_r & (|da_hits_r);

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_s     = state_r;
        rx_cnt_s    = rx_cnt_r;
        tx_cnt_s    = tx_cnt_r;
        fields_ok_s = fields_ok_r;
        da_hits_s   = da_hits_r;
        sha_spa_s   = sha_spa_r;
        m_tvalid_s  = m_tvalid_r;
        m_tuser_s   = m_tuser_r;
        m_tdata_s   = m_tdata_r;

        case (state_r)
            ST_RX: begin
                if (rx_beat_s) begin
                    // Byte 0 restarts the running match flags.
                    fields_ok_s = (first_s | fields_ok_r) & req_byte_ok(rx_cnt_r, S_AXIS_TDATA);
                    da_hits_s   = (first_s ? 2'b11 : da_hits_r) & da_byte_hits(rx_cnt_r, S_AXIS_TDATA);
                    if ((rx_cnt_r >= 8'd22) && (rx_cnt_r <= 8'd31)) begin
                        sha_spa_s = {sha_spa_r[71:0], S_AXIS_TDATA};
                    end else begin
                        sha_spa_s = sha_spa_r;
                    end
                    if (S_AXIS_TUSER) begin
                        if (rx_cnt_r == 8'd41) begin
                            state_s = ST_CHECK;
                        end else begin
                            // Runt frame: forget it and wait for the next one.
                            state_s  = ST_RX;
                            rx_cnt_s = 8'd0;
                        end
                    end else if (rx_cnt_r == 8'd41) begin
                        state_s  = ST_SKIP;
                        rx_cnt_s = 8'd42;
                    end else begin
                        rx_cnt_s = rx_cnt_r + 8'd1;
                    end
                end else begin
                    state_s = ST_RX;
                end
            end

            ST_SKIP: begin
                if (rx_beat_s) begin
                    if (S_AXIS_TUSER) begin
                        state_s = ST_CHECK;
                    end else if (rx_cnt_r != 8'd255) begin
                        rx_cnt_s = rx_cnt_r + 8'd1;
                    end else begin
                        rx_cnt_s = rx_cnt_r;
                    end
                end else begin
                    state_s = ST_SKIP;
                end
            end

            ST_CHECK: begin
                rx_cnt_s = 8'd0;
                if (match_s) begin
                    state_s    = ST_TX;
                    tx_cnt_s   = 6'd0;
                    m_tvalid_s = 1'b1;
                    m_tuser_s  = 1'b0;
                    m_tdata_s  = reply_byte(6'd0, sha_spa_r);
                end else begin
                    state_s = ST_RX;
                end
            end

            ST_TX: begin
                if (tx_beat_s) begin
                    if (tx_cnt_r == 6'd41) begin
                        state_s    = ST_RX;
                        tx_cnt_s   = 6'd0;
                        m_tvalid_s = 1'b0;
                        m_tuser_s  = 1'b0;
                        m_tdata_s  = 8'h00;
                    end else begin
                        tx_cnt_s  = tx_cnt_r + 6'd1;
                        m_tdata_s = reply_byte(tx_cnt_r + 6'd1, sha_spa_r);
                        m_tuser_s = (tx_cnt_r == 6'd40);
                    end
                end else begin
                    // Downstream stall: hold the byte on the bus.
                    state_s = ST_TX;
                end
            end

            default: begin
                state_s    = ST_RX;
                rx_cnt_s   = 8'd0;
                tx_cnt_s   = 6'd0;
                m_tvalid_s = 1'b0;
                m_tuser_s  = 1'b0;
                m_tdata_s  = 8'h00;
            end
        endcase

        // Ready is registered, so it is derived from the state being entered.
        s_tready_s = (state_s == ST_RX) || (state_s == ST_SKIP);
    end

    // State, datapath and output registers.
    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            state_r     <= ST_RX;
            rx_cnt_r    <= 8'd0;
            tx_cnt_r    <= 6'd0;
            fields_ok_r <= 1'b0;
            da_hits_r   <= 2'b11;
            sha_spa_r   <= 80'd0;
            s_tready_r  <= 1'b0;
            m_tvalid_r  <= 1'b0;
            m_tuser_r   <= 1'b0;
            m_tdata_r   <= 8'h00;
        end else begin
            state_r     <= state_s;
            rx_cnt_r    <= rx_cnt_s;
            tx_cnt_r    <= tx_cnt_s;
            fields_ok_r <= fields_ok_s;
            da_hits_r   <= da_hits_s;
            sha_spa_r   <= sha_spa_s;
            s_tready_r  <= s_tready_s;
            m_tvalid_r  <= m_tvalid_s;
            m_tuser_r   <= m_tuser_s;
            m_tdata_r   <= m_tdata_s;
        end
    end

    assign S_AXIS_TREADY = s_tready_r;
    assign M_AXIS_TVALID = m_tvalid_r;
    assign M_AXIS_TUSER  = m_tuser_r;
    assign M_AXIS_TDATA  = m_tdata_r;

endmodule

// File: tb/tb_arp_responder.sv
// -----------------------------------------------------------------------------
// tb_arp_responder
//
// Table of request frames with the expected reply decision, driven into
// arp_responder. Expected reply bytes are built here from the request fields
// and queued when a frame is sent; a monitor pops and compares each accepted
// output byte, and checks that stalled bytes are held. Hand-written sequences
// cover the runt frame and reset in the middle of a reply.
// -----------------------------------------------------------------------------
module tb_arp_responder;

    localparam logic [31:0] DUT_IP  = 32'h1122_3344;
    localparam logic [47:0] DUT_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tready;
    logic       s_tvalid = 1'b0;
    logic       s_tuser = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       m_tready;
    logic       m_tvalid;
    logic       m_tuser;
    logic [7:0] m_tdata;

    arp_responder #(.P_DUT_IPV4(DUT_IP), .P_DUT_MAC(DUT_MAC)) dut (
        .I_CLK(clk), .I_RESET(rst_n),
        .S_AXIS_TREADY(s_tready), .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TUSER(s_tuser), .S_AXIS_TDATA(s_tdata),
        .M_AXIS_TREADY(m_tready), .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TUSER(m_tuser), .M_AXIS_TDATA(m_tdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] da;
        logic [15:0] etype;
        logic [15:0] oper;
        logic [31:0] tpa;
        logic [47:0] sha;
        logic [31:0] spa;
        int          len;
        bit          gaps;
        bit          tog;
        bit          exp_reply;
    } vec_t;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] sb_q[$];
    bit         tog_mode = 1'b0;
    bit         hold_pend = 1'b0;
    logic [8:0] hold_val;
    int         beat_idx = 0;
    logic [7:0] frame[300];
    vec_t       vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                                input logic [31:0] tpa, input logic [47:0] sha, input logic [31:0] spa,
                                input int len, input bit gaps, input bit tog, input bit exp_reply);
        vec_t v;
        v.da = da; v.etype = et; v.oper = op; v.tpa = tpa; v.sha = sha; v.spa = spa;
        v.len = len; v.gaps = gaps; v.tog = tog; v.exp_reply = exp_reply;
        return v;
    endfunction

    task automatic build_req(input vec_t v);
        for (int i = 0; i < 300; i++) frame[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            frame[i]      = v.da[47-8*i -: 8];
            frame[6+i]    = v.sha[47-8*i -: 8];
            frame[22+i]   = v.sha[47-8*i -: 8];
        end
        frame[12] = v.etype[15:8]; frame[13] = v.etype[7:0];
        frame[14] = 8'h00; frame[15] = 8'h01;
        frame[16] = 8'h08; frame[17] = 8'h00;
        frame[18] = 8'h06; frame[19] = 8'h04;
        frame[20] = v.oper[15:8]; frame[21] = v.oper[7:0];
        for (int i = 0; i < 4; i++) begin
            frame[28+i] = v.spa[31-8*i -: 8];
            frame[38+i] = v.tpa[31-8*i -: 8];
        end
    endtask

    task automatic push_reply(input logic [47:0] sha, input logic [31:0] spa);
        logic [7:0] r[42];
        for (int i = 0; i < 6; i++) begin
            r[i]    = sha[47-8*i -: 8];
            r[6+i]  = DUT_MAC[47-8*i -: 8];
            r[22+i] = DUT_MAC[47-8*i -: 8];
            r[32+i] = sha[47-8*i -: 8];
        end
        r[12] = 8'h08; r[13] = 8'h06; r[14] = 8'h00; r[15] = 8'h01;
        r[16] = 8'h08; r[17] = 8'h00; r[18] = 8'h06; r[19] = 8'h04;
        r[20] = 8'h00; r[21] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            r[28+i] = DUT_IP[31-8*i -: 8];
            r[38+i] = spa[31-8*i -: 8];
        end
        for (int i = 0; i < 42; i++) sb_q.push_back({(i == 41), r[i]});
    endtask

    // Sends frame[0..len-1], TUSER on the last byte; returns just after the
    // rising edge that accepted the last byte.
    task automatic send_frame(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 7 == 3)) begin
                @(negedge clk);
                s_tvalid = 1'b0;
                @(negedge clk);
            end
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = frame[i];
            s_tuser  = (i == len - 1);
            begin
                int w = 0;
                while (!s_tready && w < 1000) begin
                    @(negedge clk);
                    w++;
                end
                if (!s_tready) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_ready_timeout: got 0 expected 1 at byte %0d", i);
                    s_tvalid = 1'b0;
                    s_tuser  = 1'b0;
                    return;
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_drain(input string nm);
        int w = 0;
        while (sb_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain_timeout: got %0d bytes left expected 0", nm, sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
        check({nm, "_idle_vld"}, m_tvalid, 0);
        check({nm, "_idle_rdy"}, s_tready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        tog_mode = v.tog;
        build_req(v);
        if (v.exp_reply) push_reply(v.sha, v.spa);
        send_frame(v.len, v.gaps);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        check({nm, "_check_rdy"}, s_tready, 0);
        check({nm, "_check_vld"}, m_tvalid, 0);
        @(negedge clk);
        check({nm, "_lat_vld"}, m_tvalid, v.exp_reply);
        check({nm, "_lat_rdy"}, s_tready, !v.exp_reply);
        wait_drain(nm);
        tog_mode = 1'b0;
    endtask

    // Output monitor: drives M_AXIS_TREADY, checks held data during stalls and
    // compares every accepted byte against the scoreboard.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (hold_pend && rst_n) begin
                check("hold_vld", m_tvalid, 1);
                check("hold_data", {m_tuser, m_tdata}, hold_val);
            end
            hold_pend = 1'b0;
            m_tready = tog_mode ? ~m_tready : 1'b1;
            if (m_tvalid && rst_n) begin
                if (m_tready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected no output", {m_tuser, m_tdata});
                    end else begin
                        logic [8:0] e;
                        e = sb_q.pop_front();
                        check($sformatf("reply_byte%0d", beat_idx), {m_tuser, m_tdata}, e);
                        beat_idx = (beat_idx == 41) ? 0 : beat_idx + 1;
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = {m_tuser, m_tdata};
                end
            end
        end
    end

    initial begin
        vecs[0] = mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3344, 48'h0000_EEEE_FFFF, 32'hAABB_CCDD, 42, 0, 0, 1);
        vecs[1] = mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3345, 48'h0000_EEEE_FFFF, 32'hAABB_CCDD, 42, 0, 0, 0);
        vecs[2] = mk(BCAST, 16'h0806, 16'h0002, 32'h1122_3344, 48'h0000_EEEE_FFFF, 32'hAABB_CCDD, 42, 0, 0, 0);
        vecs[3] = mk(BCAST, 16'h0800, 16'h0001, 32'h1122_3344, 48'h0000_EEEE_FFFF, 32'hAABB_CCDD, 42, 0, 0, 0);
        vecs[4] = mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3344, 48'h1234_5678_9ABC, 32'h0A00_0001, 60, 0, 0, 1);
        vecs[5] = mk(DUT_MAC, 16'h0806, 16'h0001, 32'h1122_3344, 48'hA1A2_A3A4_A5A6, 32'hC0A8_0001, 42, 0, 0, 1);
        vecs[6] = mk(48'h0A0B_0C0D_0E0F, 16'h0806, 16'h0001, 32'h1122_3344, 48'h0102_0304_0506, 32'h0708_090A, 42, 0, 0, 1);
`ifdef ARP_DA_FILTER_EN
        vecs[6].exp_reply = 1'b0;
`else
        vecs[6].exp_reply = 1'b1;
`endif
        vecs[7] = mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3344, {16'h0, $urandom()}, $urandom(), 42, 1, 0, 1);
        vecs[8] = mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3344, 48'hDEAD_BEEF_0042, 32'h5566_7788, 60, 0, 1, 1);
        vecs[9] = mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3344, 48'h0F0E_0D0C_0B0A, 32'h0908_0706, 300, 0, 0, 1);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tdata", m_tdata, 0);
        rst_n = 1'b1;
        #1;
        check("rel_rdy_before_clk", s_tready, 0);
        @(posedge clk);
        #1;
        check("rel_rdy_after_clk", s_tready, 1);

        for (int k = 0; k < 10; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Runt frame, then a valid request: only the second one is answered.
        build_req(vecs[0]);
        send_frame(21, 0);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        check("runt_rdy", s_tready, 1);
        repeat (5) @(negedge clk);
        check("runt_no_vld", m_tvalid, 0);
        run_vec(mk(BCAST, 16'h0806, 16'h0001, 32'h1122_3344, 48'h0000_1111_2222, 32'h3333_4444, 42, 0, 0, 1),
                "after_runt");

        // Reset while reply byte 10 is on the bus.
        build_req(vecs[0]);
        push_reply(vecs[0].sha, vecs[0].spa);
        send_frame(42, 0);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        begin
            int w = 0;
            @(posedge clk);
            #2;
            while (sb_q.size() > 32 && w < 500) begin
                @(posedge clk);
                #2;
                w++;
            end
        end
        check("pre_reset_bytes_left", sb_q.size(), 32);
        rst_n = 1'b0;
        #1;
        check("mid_reset_vld", m_tvalid, 0);
        check("mid_reset_rdy", s_tready, 0);
        check("mid_reset_tuser", m_tuser, 0);
        check("mid_reset_tdata", m_tdata, 0);
        sb_q.delete();
        beat_idx  = 0;
        hold_pend = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset_vld", m_tvalid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rdy", s_tready, 1);
        run_vec(vecs[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
